mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller that owns the HI/LO register pair and sequences an iterative radix-2 datapath for MULT/MULTU/DIV/DIVU. It also performs single-cycle MTHI/MTLO writes. It sits beside EX, takes operands already resolved by ID forwarding, and raises a stall request so the pipeline holds while an operation iterates. HI/LO outputs feed EX for MFHI/MFLO.

---
 rtl/mdu_ctrl_pkg.sv | 35 +++
 rtl/mdu_ctrl_iter_step.sv | 38 +++
 rtl/mdu_ctrl.sv | 158 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide controller: op codes, FSM states,
// iteration count and the magnitude helper used when latching signed operands.
// Imported by mdu_ctrl and mdu_iter_step.
package mdu_ctrl_pkg;

  // Iterations per multiply/divide; tied to the 32-bit operand width.
  localparam int MDU_ITER_DEF = 32;

  // Operation encodings carried on the ID_TO_EX bus.
  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } mdu_step_e;

  // Unsigned magnitude of a two's-complement word (0x80000000 maps to itself,
  // which is the correct unsigned magnitude).
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_ctrl_iter_step.sv
// Purpose: one radix-2 iteration, shift-add multiply or restoring divide.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module mdu_iter_step
  import mdu_ctrl_pkg::*;
(
  input  mdu_step_e   mode,
  input  logic [63:0] acc_in,
  input  logic [31:0] operand,
  output logic [63:0] acc_out,
  output logic        q_bit
);

  logic [32:0] prod_sum;
  logic        div_ok;
  logic [31:0] div_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}; add the
  // multiplicand into the top half when the current multiplier bit is set,
  // then shift right keeping the carry.
  // Divide: acc = {partial remainder, remaining dividend / quotient bits};
  // shift left, and if the shifted remainder (33 bits) covers the divisor,
  // subtract and emit a 1 quotient bit. The difference always fits 32 bits.
  always_comb begin
    prod_sum = {1'b0, acc_in[63:32]} + {1'b0, operand};
    div_ok   = ({1'b0, acc_in[63:31]} >= {1'b0, operand});
    div_diff = acc_in[62:31] - operand;
    acc_out  = '0;
    q_bit    = 1'b0;
    if (mode == STEP_MUL) begin
      acc_out = acc_in[0] ? {prod_sum, acc_in[31:1]} : {1'b0, acc_in[63:1]};
    end else begin
      acc_out = {(div_ok ? div_diff : acc_in[62:31]), acc_in[30:0], 1'b0};
      q_bit   = div_ok;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Purpose: HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Latency: mul/div results visible 34 cycles after accept; MTHI/MTLO next cycle.
// Backpressure: stallreq holds IF/ID/EX from accept through the last iteration.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MDU_ITER = MDU_ITER_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stallreq,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        neg;
  logic        rneg;
  logic        is_div;

  logic        md_op;
  logic        last_iter;
  mdu_step_e   step_mode;
  logic [63:0] step_acc;
  logic        step_q;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign md_op     = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
                     (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  assign last_iter = (cnt == 5'(MDU_ITER - 1));
  assign step_mode = (state == MDU_DIV) ? STEP_DIV : STEP_MUL;

  mdu_iter_step u_step (
    .mode    (step_mode),
    .acc_in  (acc),
    .operand (opnd),
    .acc_out (step_acc),
    .q_bit   (step_q)
  );

  // Sign-corrected results, consumed only in DONE.
  assign prod_fix = neg  ? (~acc + 64'd1)          : acc;
  assign quot_fix = neg  ? (~acc[31:0] + 32'd1)    : acc[31:0];
  assign rem_fix  = rneg ? (~acc[63:32] + 32'd1)   : acc[63:32];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_nxt;
  end

  // Next state and stall/busy; start is ignored outside IDLE because the same
  // instruction is still sitting in EX. Reset forces the outputs low at once.
  always_comb begin
    state_nxt = state;
    stallreq  = 1'b0;
    busy      = 1'b0;
    case (state)
      MDU_IDLE: begin
        if (start && md_op) begin
          stallreq  = 1'b1;
          state_nxt = ((op == MDU_OP_DIV) || (op == MDU_OP_DIVU)) ? MDU_DIV : MDU_MUL;
        end
      end
      MDU_MUL, MDU_DIV: begin
        stallreq = 1'b1;
        busy     = 1'b1;
        if (last_iter) state_nxt = MDU_DONE;
      end
      MDU_DONE: state_nxt = MDU_IDLE;
      default:  state_nxt = MDU_IDLE;
    endcase
    if (rst) begin
      stallreq = 1'b0;
      busy     = 1'b0;
    end
  end

  // Operand latch, iteration datapath, counter and HI/LO write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      is_div <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (start) begin
            cnt <= '0;
            case (op)
              MDU_OP_MULT: begin
                opnd   <= mag32(src_a);
                acc    <= {32'd0, mag32(src_b)};
                neg    <= src_a[31] ^ src_b[31];
                rneg   <= 1'b0;
                is_div <= 1'b0;
              end
              MDU_OP_MULTU: begin
                opnd   <= src_a;
                acc    <= {32'd0, src_b};
                neg    <= 1'b0;
                rneg   <= 1'b0;
                is_div <= 1'b0;
              end
              MDU_OP_DIV: begin
                opnd   <= mag32(src_b);
                acc    <= {32'd0, mag32(src_a)};
                neg    <= src_a[31] ^ src_b[31];
                rneg   <= src_a[31];
                is_div <= 1'b1;
              end
              MDU_OP_DIVU: begin
                opnd   <= src_b;
                acc    <= {32'd0, src_a};
                neg    <= 1'b0;
                rneg   <= 1'b0;
                is_div <= 1'b1;
              end
              MDU_OP_MTHI: hi <= src_a;
              MDU_OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        MDU_MUL, MDU_DIV: begin
          acc <= step_acc | {63'd0, step_q};
          cnt <= cnt + 5'd1;
        end
        MDU_DONE: begin
          if (is_div) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            lo <= prod_fix[31:0];
            hi <= prod_fix[63:32];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: scoreboard of expected HI/LO pushed at issue and popped
// when the result becomes visible; one task per scenario.
// Stall/busy lengths and reset behaviour are checked inline in each task.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stallreq;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  mdu_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stallreq (stallreq),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic for the randomized ops.
  function automatic void model_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eh, output logic [31:0] el);
    logic [63:0] p;
    logic signed [31:0] sa, sbv;
    sa = a;
    sbv = b;
    p = '0;
    eh = '0;
    el = '0;
    case (o)
      MDU_OP_MULT: begin
        p  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        eh = p[63:32];
        el = p[31:0];
      end
      MDU_OP_MULTU: begin
        p  = {32'd0, a} * {32'd0, b};
        eh = p[63:32];
        el = p[31:0];
      end
      MDU_OP_DIV: begin
        el = sa / sbv;
        eh = sa % sbv;
      end
      default: begin
        el = a / b;
        eh = a % b;
      end
    endcase
  endfunction

  // Issue one mul/div, hold start while the pipeline would hold it (through
  // DONE), then release. Returns measured stall/busy cycles and HI during DONE.
  task automatic drive_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          output int stall_n, output int busy_n,
                          output logic [31:0] hi_done, output bit timeout);
    int k;
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
    model_hi = eh;
    model_lo = el;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    #1;
    stall_n = 0;
    busy_n  = 0;
    k       = 0;
    while (stallreq === 1'b1 && k < 100) begin
      stall_n++;
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      #1;
      k++;
    end
    timeout = (k >= 100);
    hi_done = hi;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    op    = MDU_OP_MULT;
    src_a = '0;
    src_b = '0;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL reset_stallreq got=%b exp=0", stallreq); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multu_max();
    int st, bz;
    logic [31:0] hd, hi_before;
    bit to;
    exp_t e;
    hi_before = hi;
    drive_md(MDU_OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, st, bz, hd, to);
    e = sb.pop_front();
    checks++; if (to) begin failures++; $display("FAIL multu_timeout stall never dropped"); end
    checks++; if (st != 33) begin failures++; $display("FAIL multu_stall_len got=%0d exp=33", st); end
    checks++; if (bz != 32) begin failures++; $display("FAIL multu_busy_len got=%0d exp=32", bz); end
    checks++; if (hd !== hi_before) begin failures++; $display("FAIL multu_hi_in_done got=%h exp=%h", hd, hi_before); end
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL multu_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL multu_lo got=%h exp=%h", lo, e.lo); end
  endtask

  task automatic test_mult_signed();
    int st, bz;
    logic [31:0] hd;
    bit to;
    exp_t e;
    drive_md(MDU_OP_MULT, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, st, bz, hd, to);
    e = sb.pop_front();
    checks++; if (st != 33) begin failures++; $display("FAIL mult_stall_len got=%0d exp=33", st); end
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL mult_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL mult_lo got=%h exp=%h", lo, e.lo); end
  endtask

  task automatic test_div_signed();
    int st, bz;
    logic [31:0] hd;
    bit to;
    exp_t e;
    drive_md(MDU_OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, st, bz, hd, to);
    e = sb.pop_front();
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL div_neg7_2_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL div_neg7_2_lo got=%h exp=%h", lo, e.lo); end
    drive_md(MDU_OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, st, bz, hd, to);
    e = sb.pop_front();
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL div_7_neg2_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL div_7_neg2_lo got=%h exp=%h", lo, e.lo); end
    checks++; if (bz != 32) begin failures++; $display("FAIL div_busy_len got=%0d exp=32", bz); end
  endtask

  task automatic test_divu_zero();
    int st, bz;
    logic [31:0] hd;
    bit to;
    exp_t e;
    drive_md(MDU_OP_DIVU, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, st, bz, hd, to);
    e = sb.pop_front();
    checks++; if (st != 33) begin failures++; $display("FAIL divu0_stall_len got=%0d exp=33", st); end
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL divu0_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL divu0_lo got=%h exp=%h", lo, e.lo); end
  endtask

  task automatic test_mthi_mtlo();
    exp_t e;
    e.hi = 32'h12345678;
    e.lo = model_lo;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1;
    op    = MDU_OP_MTHI;
    src_a = 32'h12345678;
    #1;
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL mthi_stallreq got=%b exp=0", stallreq); end
    @(negedge clk);
    op    = MDU_OP_MTLO;
    src_a = 32'h9ABCDEF0;
    e.lo  = 32'h9ABCDEF0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL mtlo_stallreq got=%b exp=0", stallreq); end
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL mthi_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL mthi_lo_unchanged got=%h exp=%h", lo, e.lo); end
    @(negedge clk);
    start = 1'b0;
    #1;
    e = sb.pop_front();
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL mtlo_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL mtlo_lo got=%h exp=%h", lo, e.lo); end
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  task automatic test_back_to_back_random();
    int st, bz;
    logic [31:0] hd, a, b, eh, el;
    logic [2:0] o;
    bit to;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      o = 3'($urandom_range(0, 3));
      if ((o == MDU_OP_DIV || o == MDU_OP_DIVU) && b == 32'd0) b = 32'd3;
      if (o == MDU_OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
      model_md(o, a, b, eh, el);
      drive_md(o, a, b, eh, el, st, bz, hd, to);
      e = sb.pop_front();
      checks++; if (st != 33) begin failures++; $display("FAIL rand%0d_stall_len got=%0d exp=33", i, st); end
      checks++; if (hi !== e.hi) begin failures++; $display("FAIL rand%0d_hi op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, hi, e.hi); end
      checks++; if (lo !== e.lo) begin failures++; $display("FAIL rand%0d_lo op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, lo, e.lo); end
    end
  endtask

  task automatic test_reset_mid_op();
    int st, bz;
    logic [31:0] hd;
    bit to;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    op    = MDU_OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd3;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (stallreq !== 1'b0) begin failures++; $display("FAIL midrst_stallreq got=%b exp=0", stallreq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL midrst_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin failures++; $display("FAIL midrst_lo got=%h exp=0", lo); end
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    model_hi = '0;
    model_lo = '0;
    drive_md(MDU_OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, st, bz, hd, to);
    e = sb.pop_front();
    checks++; if (st != 33) begin failures++; $display("FAIL postrst_stall_len got=%0d exp=33", st); end
    checks++; if (hi !== e.hi) begin failures++; $display("FAIL postrst_hi got=%h exp=%h", hi, e.hi); end
    checks++; if (lo !== e.lo) begin failures++; $display("FAIL postrst_lo got=%h exp=%h", lo, e.lo); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_divu_zero();
    test_mthi_mtlo();
    test_back_to_back_random();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
